parking_sensor_driver: RTL and testbench
========================================

# parking_sensor_driver

Stimulus generator producing the two-sensor (A outer, B inner) waveform of a car crossing the parking-lot gate. It accepts enter/exit commands over a valid/ready handshake and drives SIG_A/SIG_B through the exact phase sequence the parking-lot entry/exit decoder recognises, while tracking the expected lot occupancy. It is the encoder counterpart of that decoder: used in the FPGA top level for self-test and in benches as the sensor model.

## Interface
- PHASE_CYCLES, 4: clock cycles each sensor phase is held; must be ≥3, because the decoder's synchroniser needs 2 cycles.
- CAPACITY, 16: lot capacity; COUNT saturates against it.
- CLOCK_50  in  1  system clock, all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- CMD_VALID  in  1  command request.
- CMD_DIR  in  1  0 = enter, 1 = exit; sampled on handshake.
- CMD_READY  out  1  high only in IDLE.
- CMD_ABORT  in  1  car reverses mid-crossing (see Configuration).
- SIG_A  out  1  outer sensor, registered.
- SIG_B  out  1  inner sensor, registered.
- BUSY  out  1  high in any state except IDLE.
- DONE  out  1  one-cycle pulse: crossing completed.
- ABORTED  out  1  one-cycle pulse: crossing backed out.
- REJECT  out  1  one-cycle pulse: command refused (full/empty).
- COUNT  out  $clog2(CAPACITY+1)  current occupancy.

## Operation
- States: IDLE, PH1, PH2, PH3, GAP. Direction register holds the accepted CMD_DIR. Reversing flag is set by abort.
- Sensor levels (A,B) by state:
  - Enter: PH1 = 1,0; PH2 = 1,1; PH3 = 0,1.
  - Exit: PH1 = 0,1; PH2 = 1,1; PH3 = 1,0.
  - IDLE and GAP: 0,0.
- Handshake: CMD_VALID && CMD_READY accepts the command.
  - Enter with COUNT==CAPACITY, or exit with COUNT==0: REJECT pulses in the next cycle and the block stays in IDLE with no waveform.
  - Otherwise the block moves to PH1.
- Each of PH1, PH2, PH3 and GAP lasts exactly PHASE_CYCLES cycles. Forward order is PH1→PH2→PH3→GAP→IDLE.
- Completion: on entry to GAP (forward path), DONE pulses. In the same cycle COUNT increments for enter or decrements for exit.
- COUNT never wraps. The full/empty checks guarantee no overflow or underflow.
- CMD_VALID while BUSY is ignored and not queued. The command source holds it until CMD_READY.

## Timing
- Reset values: SIG_A=0, SIG_B=0, CMD_READY=1 (from the cycle after reset), BUSY=0, DONE=0, ABORTED=0, REJECT=0, COUNT=0, state IDLE.
- Handshake in cycle T:
  - SIG_A/SIG_B show PH1 levels from cycle T+1.
  - PH2 starts at T+1+P, PH3 at T+1+2P, GAP at T+1+3P (P = PHASE_CYCLES).
  - DONE and the COUNT update occur at T+1+3P.
  - CMD_READY returns at T+1+4P.
- A reject returns to ready immediately: REJECT at T+1, CMD_READY stays 1.
- Reset asserted mid-crossing: at the next edge the block returns to reset values. SIG lines drop to 0 together, and the count is lost.

## Configuration
- PARK_ABORT_EN defined:
  - CMD_ABORT is sampled in PH1–PH3 while the reversing flag is clear. It sets the flag and restarts the phase timer.
  - The sequence then walks backward: PH3→PH2→PH1→GAP. Each step holds P cycles.
  - Abort in PH1 goes straight to GAP after P cycles of PH1 levels.
  - On entry to GAP while reversing, ABORTED pulses instead of DONE, and COUNT is unchanged.
  - Abort in IDLE, in GAP, or while already reversing is ignored.
- PARK_ABORT_EN undefined: the CMD_ABORT port is present but ignored, ABORTED is tied 0, and no reversing logic is built.

## Structure
- Shared package parking_pkg:
  - state enum (IDLE, PH1, PH2, PH3, GAP);
  - direction enum DIR_ENTER=0, DIR_EXIT=1;
  - PHASE_MIN=3 constant.
- Sub-module phase_timer:
  - parameter PHASE_CYCLES;
  - inputs: load, enable;
  - output: expire, a pulse on the last cycle of a phase;
  - counter width $clog2(PHASE_CYCLES).

## Test plan
- P=4, CAPACITY=2, enter at T=10:
  - A=1 for cycles 11–18;
  - B=1 for cycles 15–22;
  - DONE at 23 and COUNT=1;
  - CMD_READY at 27.
  - Decoder loopback gives exactly one ENTER.
- Two enters, then a third enter: the third gives REJECT one cycle after accept, no SIG activity, COUNT stays 2. An exit then gives COUNT=1, and the loopback gives one EXIT.
- Exit at COUNT=0: REJECT pulse, SIG_A=SIG_B=0 throughout.
- CMD_VALID held during an active enter: ignored, and the second command is accepted at the first cycle CMD_READY=1.
- PARK_ABORT_EN defined, abort during enter PH3:
  - levels return to 1,1 then 1,0 (P cycles each), then 0,0;
  - ABORTED pulses once, DONE=0, COUNT unchanged;
  - decoder loopback gives no ENTER.
  - Without the macro the same stimulus completes normally with DONE.
- RST asserted at PH2 (A=B=1): next cycle all outputs are at reset values and COUNT=0. A fresh enter then completes normally.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types for the parking-gate sensor driver: crossing states, direction
// encoding and the sensor level table for each state.
package parking_pkg;

   typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, GAP} state_t;
   typedef enum logic {DIR_ENTER = 1'b0, DIR_EXIT = 1'b1} dir_t;

   // The decoder's two-flop synchroniser needs phases of at least this length.
   localparam int PHASE_MIN = 3;

   // {A,B} sensor levels shown while in a given state.
   function automatic logic [1:0] sensor_levels(input state_t s, input dir_t d);
      logic [1:0] ab;
      ab = 2'b00;
      case (s)
         PH1:     ab = (d == DIR_ENTER) ? 2'b10 : 2'b01;
         PH2:     ab = 2'b11;
         PH3:     ab = (d == DIR_ENTER) ? 2'b01 : 2'b10;
         default: ab = 2'b00;
      endcase
      return ab;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase duration counter: restarts on load, counts while enabled and flags
// the last cycle of each PHASE_CYCLES-long phase.
module phase_timer #(
   parameter int PHASE_CYCLES = 4
) (
   input  logic CLOCK_50,
   input  logic RST,
   input  logic load,
   input  logic enable,
   output logic expire
);

   localparam int CNT_W = $clog2(PHASE_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PHASE_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge CLOCK_50) begin
      if (RST)
         cnt <= '0;
      else if (load)
         cnt <= '0;
      else if (enable)
         cnt <= cnt + CNT_W'(1);
   end

   assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/parking_sensor_driver.sv
// Two-sensor gate waveform generator with occupancy tracking.
// Optional reverse-out support is built when PARK_ABORT_EN is defined.
module parking_sensor_driver
   import parking_pkg::*;
#(
   parameter int PHASE_CYCLES = 4,
   parameter int CAPACITY     = 16
) (
   input  logic                           CLOCK_50,
   input  logic                           RST,
   input  logic                           CMD_VALID,
   input  logic                           CMD_DIR,
   output logic                           CMD_READY,
   input  logic                           CMD_ABORT,
   output logic                           SIG_A,
   output logic                           SIG_B,
   output logic                           BUSY,
   output logic                           DONE,
   output logic                           ABORTED,
   output logic                           REJECT,
   output logic [$clog2(CAPACITY+1)-1:0]  COUNT
);

   localparam int CNT_W = $clog2(CAPACITY + 1);
   localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
   localparam int PHASE_EFF = (PHASE_CYCLES < PHASE_MIN) ? PHASE_MIN : PHASE_CYCLES;

   state_t           state, state_nxt;
   dir_t             dir, dir_nxt, cmd_dir;
   logic [CNT_W-1:0] count_nxt;
   logic             load, expire, done_nxt, reject_nxt;
   logic             reversing, abort_take;

   assign cmd_dir   = dir_t'(CMD_DIR);
   assign CMD_READY = (state == IDLE);
   assign BUSY      = !CMD_READY;

   phase_timer #(.PHASE_CYCLES(PHASE_EFF)) u_timer (
      .CLOCK_50 (CLOCK_50),
      .RST      (RST),
      .load     (load),
      .enable   (BUSY),
      .expire   (expire)
   );

`ifdef PARK_ABORT_EN
   logic aborted_q;

   assign abort_take = CMD_ABORT && !reversing && (state inside {PH1, PH2, PH3});

   // A reversing crossing always leaves through PH1 into GAP.
   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         reversing <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         if (abort_take)
            reversing <= 1'b1;
         else if (state == GAP && expire)
            reversing <= 1'b0;
         aborted_q <= reversing && (state == PH1) && expire;
      end
   end

   assign ABORTED = aborted_q;
`else
   assign abort_take = 1'b0;
   assign reversing  = 1'b0;
   assign ABORTED    = CMD_ABORT & 1'b0;   // port kept for a uniform pinout
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch is inferred.
      state_nxt  = state;
      dir_nxt    = dir;
      count_nxt  = COUNT;
      load       = 1'b0;
      done_nxt   = 1'b0;
      reject_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (CMD_VALID) begin
               if ((cmd_dir == DIR_ENTER && COUNT == CAP) ||
                   (cmd_dir == DIR_EXIT  && COUNT == '0)) begin
                  reject_nxt = 1'b1;
               end else begin
                  state_nxt = PH1;
                  dir_nxt   = cmd_dir;
                  load      = 1'b1;
               end
            end
         end
         PH1: begin
            if (abort_take) begin
               load = 1'b1;
            end else if (expire) begin
               load      = 1'b1;
               state_nxt = reversing ? GAP : PH2;
            end
         end
         PH2: begin
            if (abort_take) begin
               load = 1'b1;
            end else if (expire) begin
               load      = 1'b1;
               state_nxt = reversing ? PH1 : PH3;
            end
         end
         PH3: begin
            if (abort_take) begin
               load = 1'b1;
            end else if (expire) begin
               load = 1'b1;
               if (reversing) begin
                  state_nxt = PH2;
               end else begin
                  state_nxt = GAP;
                  done_nxt  = 1'b1;
                  count_nxt = (dir == DIR_ENTER) ? COUNT + CNT_W'(1) : COUNT - CNT_W'(1);
               end
            end
         end
         GAP: begin
            if (expire)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Sensor outputs are registered from the next state so they align with it.
   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         state  <= IDLE;
         dir    <= DIR_ENTER;
         COUNT  <= '0;
         SIG_A  <= 1'b0;
         SIG_B  <= 1'b0;
         DONE   <= 1'b0;
         REJECT <= 1'b0;
      end else begin
         state          <= state_nxt;
         dir            <= dir_nxt;
         COUNT          <= count_nxt;
         {SIG_A, SIG_B} <= sensor_levels(state_nxt, dir_nxt);
         DONE           <= done_nxt;
         REJECT         <= reject_nxt;
      end
   end

endmodule

// File: tb/tb_parking_sensor_driver.sv
// Bench for parking_sensor_driver: a schedule-based crossing model checked every
// cycle, directed scenarios with literal timing, then randomized traffic.
module tb_parking_sensor_driver;

   localparam int P   = 4;
   localparam int CAP = 2;
`ifdef PARK_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   logic       CLOCK_50, RST, CMD_VALID, CMD_DIR, CMD_ABORT;
   logic       CMD_READY, SIG_A, SIG_B, BUSY, DONE, ABORTED, REJECT;
   logic [1:0] COUNT;

   parking_sensor_driver #(.PHASE_CYCLES(P), .CAPACITY(CAP)) dut (
      .CLOCK_50  (CLOCK_50),
      .RST       (RST),
      .CMD_VALID (CMD_VALID),
      .CMD_DIR   (CMD_DIR),
      .CMD_READY (CMD_READY),
      .CMD_ABORT (CMD_ABORT),
      .SIG_A     (SIG_A),
      .SIG_B     (SIG_B),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .ABORTED   (ABORTED),
      .REJECT    (REJECT),
      .COUNT     (COUNT)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   int vectors = 0;
   int miscompares = 0;
   int cyc = -1;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model: per-crossing schedule ----------------
   typedef struct {int ph; bit done; bit abt;} ent_t;
   ent_t sched[$];
   ent_t cur = '{0, 1'b0, 1'b0};
   int   m_count = 0;
   bit   m_dir = 1'b0;
   bit   m_rev = 1'b0;
   bit   m_rej = 1'b0;

   function automatic logic [1:0] levels(input int ph, input bit d);
      case (ph)
         1:       return d ? 2'b01 : 2'b10;
         2:       return 2'b11;
         3:       return d ? 2'b10 : 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   always @(posedge CLOCK_50) begin
      cyc++;
      if (RST) begin
         sched.delete();
         cur     = '{0, 1'b0, 1'b0};
         m_count = 0;
         m_rev   = 1'b0;
         m_rej   = 1'b0;
      end else begin
         m_rej = 1'b0;
         if (ABORT_EN && CMD_ABORT && !m_rev && cur.ph >= 1 && cur.ph <= 3) begin
            sched.delete();
            m_rev = 1'b1;
            for (int p = cur.ph; p >= 1; p--)
               for (int k = 0; k < P; k++) sched.push_back('{p, 1'b0, 1'b0});
            for (int k = 0; k < P; k++) sched.push_back('{4, 1'b0, k == 0});
         end else if (cur.ph == 0 && CMD_VALID) begin
            if ((!CMD_DIR && m_count == CAP) || (CMD_DIR && m_count == 0)) begin
               m_rej = 1'b1;
            end else begin
               m_dir = CMD_DIR;
               for (int p = 1; p <= 3; p++)
                  for (int k = 0; k < P; k++) sched.push_back('{p, 1'b0, 1'b0});
               for (int k = 0; k < P; k++) sched.push_back('{4, k == 0, 1'b0});
            end
         end
         if (sched.size() > 0) begin
            cur = sched.pop_front();
         end else begin
            cur   = '{0, 1'b0, 1'b0};
            m_rev = 1'b0;
         end
         if (cur.done) m_count += m_dir ? -1 : 1;
      end
   end

   // ---------------- compare process + decoder loopback ----------------
   logic [1:0] dec_prev = 2'b00;
   logic [1:0] dec_hist[$];
   int dec_enter = 0, dec_exit = 0;
   int n_done = 0, n_abt = 0, n_rej = 0;

   always @(negedge CLOCK_50) begin
      logic [1:0] e_ab, lv;
      if (chk_en) begin
         e_ab = levels(cur.ph, m_dir);
         check("sig_a",   int'(SIG_A),     int'(e_ab[1]));
         check("sig_b",   int'(SIG_B),     int'(e_ab[0]));
         check("ready",   int'(CMD_READY), int'(cur.ph == 0));
         check("busy",    int'(BUSY),      int'(cur.ph != 0));
         check("done",    int'(DONE),      int'(cur.done));
         check("aborted", int'(ABORTED),   int'(cur.abt));
         check("reject",  int'(REJECT),    int'(m_rej));
         check("count",   int'(COUNT),     m_count);
         n_done += int'(DONE);
         n_abt  += int'(ABORTED);
         n_rej  += int'(REJECT);
         lv = {SIG_A, SIG_B};
         if (lv != dec_prev) begin
            if (lv == 2'b00) begin
               if (dec_hist.size() == 3 && dec_hist[0] == 2'b10 && dec_hist[1] == 2'b11 && dec_hist[2] == 2'b01)
                  dec_enter++;
               if (dec_hist.size() == 3 && dec_hist[0] == 2'b01 && dec_hist[1] == 2'b11 && dec_hist[2] == 2'b10)
                  dec_exit++;
               dec_hist.delete();
            end else begin
               dec_hist.push_back(lv);
            end
            dec_prev = lv;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge CLOCK_50);
      #2;
   endtask

   task automatic goto(input int c);
      while (cyc < c) tick();
   endtask

   task automatic timeout_fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: DUT never returned CMD_READY (cycle %0d)", name, cyc);
   endtask

   // Presents a command from the next cycle, holds it until CMD_READY, returns the handshake cycle.
   task automatic send(input bit d, output int t_acc);
      int n;
      tick();
      CMD_VALID = 1'b1;
      CMD_DIR   = d;
      t_acc     = -1;
      n         = 0;
      while (t_acc < 0 && n < 200) begin
         @(negedge CLOCK_50);
         if (CMD_READY) t_acc = cyc;
         tick();
         n++;
      end
      CMD_VALID = 1'b0;
      if (t_acc < 0) timeout_fail("send_timeout");
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      tick();
      @(negedge CLOCK_50);
      while (!CMD_READY && n < 200) begin
         tick();
         @(negedge CLOCK_50);
         n++;
      end
      if (!CMD_READY) timeout_fail("idle_timeout");
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int t, t2, ent0, ext0, done0, abt0, rej0;
      RST = 1'b1; CMD_VALID = 1'b0; CMD_DIR = 1'b0; CMD_ABORT = 1'b0;
      goto(2);
      RST    = 1'b0;
      chk_en = 1'b1;
      @(negedge CLOCK_50);
      check("rst_ready", int'(CMD_READY), 1);
      check("rst_busy",  int'(BUSY), 0);
      check("rst_sig",   int'({SIG_A, SIG_B}), 0);
      check("rst_count", int'(COUNT), 0);

      // Enter at cycle 10: literal waveform timing.
      goto(9);
      send(1'b0, t);
      check("enter_accept_cycle", t, 10);
      for (int c = 11; c <= 27; c++) begin
         goto(c);
         @(negedge CLOCK_50);
         check("lit_sig_a", int'(SIG_A), int'(c >= 11 && c <= 18));
         check("lit_sig_b", int'(SIG_B), int'(c >= 15 && c <= 22));
         check("lit_done",  int'(DONE),  int'(c == 23));
         check("lit_ready", int'(CMD_READY), int'(c >= 27));
         if (c == 23) check("lit_count_after_enter", int'(COUNT), 1);
      end
      tick();
      check("dec_one_enter", dec_enter, 1);

      // Fill the lot, third enter is refused, then one exit.
      send(1'b0, t);
      wait_idle();
      send(1'b0, t);
      @(negedge CLOCK_50);
      check("full_reject_pulse", int'(REJECT), 1);
      check("full_count_held",   int'(COUNT), 2);
      check("full_stays_ready",  int'(CMD_READY), 1);
      ext0 = dec_exit;
      send(1'b1, t);
      wait_idle();
      check("exit_count", int'(COUNT), 1);
      tick();
      check("dec_one_exit", dec_exit - ext0, 1);

      // Empty the lot, then an exit at COUNT==0 is refused.
      send(1'b1, t);
      wait_idle();
      send(1'b1, t);
      @(negedge CLOCK_50);
      check("empty_reject_pulse", int'(REJECT), 1);
      check("empty_sig_idle", int'({SIG_A, SIG_B}), 0);
      tick();
      check("reject_total", n_rej, 2);

      // Command held while busy is accepted on the first ready cycle.
      send(1'b0, t);
      send(1'b0, t2);
      check("held_accept_delay", t2 - t, 1 + 4 * P);
      wait_idle();
      check("held_count", int'(COUNT), 2);

      // Abort during enter PH3.
      send(1'b1, t);
      wait_idle();
      tick();
      ent0 = dec_enter; done0 = n_done; abt0 = n_abt;
      send(1'b0, t);
      goto(t + 10);
      CMD_ABORT = 1'b1;
      tick();
      CMD_ABORT = 1'b0;
      goto(t + 15);
      @(negedge CLOCK_50);
`ifdef PARK_ABORT_EN
      check("abort_back_ph2", int'({SIG_A, SIG_B}), 3);
      goto(t + 19);
      @(negedge CLOCK_50);
      check("abort_back_ph1", int'({SIG_A, SIG_B}), 2);
      goto(t + 23);
      @(negedge CLOCK_50);
      check("abort_pulse", int'(ABORTED), 1);
      wait_idle();
      tick();
      check("abort_count_kept", int'(COUNT), 1);
      check("abort_one_pulse", n_abt - abt0, 1);
      check("abort_no_done", n_done - done0, 0);
      check("abort_no_dec_enter", dec_enter - ent0, 0);
`else
      check("noabort_gap", int'({SIG_A, SIG_B}), 0);
      wait_idle();
      tick();
      check("noabort_count", int'(COUNT), 2);
      check("noabort_done", n_done - done0, 1);
      check("noabort_no_aborted", n_abt - abt0, 0);
      check("noabort_dec_enter", dec_enter - ent0, 1);
`endif

      // Reset in the middle of PH2.
      send(1'b1, t);
      goto(t + 6);
      @(negedge CLOCK_50);
      check("ph2_levels", int'({SIG_A, SIG_B}), 3);
      tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      @(negedge CLOCK_50);
      check("midrst_sig",   int'({SIG_A, SIG_B}), 0);
      check("midrst_count", int'(COUNT), 0);
      check("midrst_ready", int'(CMD_READY), 1);
      check("midrst_flags", int'({BUSY, DONE, ABORTED, REJECT}), 0);
      send(1'b0, t);
      wait_idle();
      check("fresh_enter_count", int'(COUNT), 1);

      // Randomized traffic including aborts and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         tick();
         RST       = ($urandom_range(399) == 0);
         CMD_VALID = ($urandom_range(2) == 0);
         CMD_DIR   = $urandom_range(1);
         CMD_ABORT = ($urandom_range(15) == 0);
      end
      tick();
      RST = 1'b0; CMD_VALID = 1'b0; CMD_ABORT = 1'b0;
      wait_idle();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
